sub_bytes_engine: RTL and testbench

Parametrised, handshaked AES SubBytes / InvSubBytes engine for the 128-bit state datapath. Accepts one 128-bit state with a per-transfer direction bit, substitutes `LANES` bytes per clock through a shared forward/inverse S-box, and presents the result on a valid/ready output port. It sits between round-key addition and the row-shift stage. It replaces the fixed, purely combinational inverse-only substitution stage with a forward/inverse, area-scalable, flow-controlled unit.

---
 rtl/sub_bytes_engine.sv | 122 ++++++++++++
 tb/tb_sub_bytes_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// Handshaked AES SubBytes / InvSubBytes engine: one 128-bit state per transfer,
// LANES bytes substituted per clock through a shared forward/inverse S-box.
module sub_bytes_engine #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [127:0]    wr_q, wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic            accept;
   logic [31:0]     base;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int unsigned i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
      logic [7:0] t;
      logic [7:0] v;
      t = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
      v = gf_inv(t);
      return inv ? v
                 : (v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63);
   endfunction

   assign accept = in_valid && (state_q == IDLE);
   assign base   = 32'(cnt_q) * LANES;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (cnt_q == CW'(N - 1)) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      if (accept) begin
         wr_d   = in_state;
         cnt_d  = '0;
         mode_d = in_mode;
      end else if (state_q == RUN) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            wr_d[(base + l) * 8 +: 8] = sbox(wr_q[(base + l) * 8 +: 8], mode_q);
         end
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      out_state = wr_q;
   end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: five instances (LANES = 1,2,4,8,16) checked
// against a stored FIPS-197 table for results, latency, backpressure and reset.
module tb_sub_bytes_engine;

   logic         clk;
   logic         rst_n;
   logic [4:0]   in_valid, in_ready, in_mode, out_valid, out_ready, busy;
   logic [127:0] in_state  [5];
   logic [127:0] out_state [5];

   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];
   int           n_checks;
   int           n_pass;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      sub_bytes_engine #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_mode   (in_mode[g]),
         .in_state  (in_state[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
         .busy      (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_tab[s[8*i +: 8]] : fwd_tab[s[8*i +: 8]];
      return r;
   endfunction

   task automatic xfer(input int d, input logic m, input logic [127:0] s,
                       output logic [127:0] res, output int lat);
      int w;
      @(negedge clk);
      out_ready[d] = 1'b0;
      in_mode[d]   = m;
      in_state[d]  = s;
      in_valid[d]  = 1'b1;
      w = 0;
      while (!in_ready[d] && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("accept_d%0d", d), 128'(in_ready[d]), 128'(1));
      @(negedge clk);
      in_valid[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = out_state[d];
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
   endtask

   task automatic back_to_back(input int d, input logic [127:0] s0);
      int n, prev, acc_n, out_n, w;
      n = 16 >> d;
      prev = 0;
      acc_n = 0;
      out_n = 0;
      @(negedge clk);
      out_ready[d] = 1'b1;
      in_state[d]  = s0;
      in_valid[d]  = 1'b1;
      for (int c = 0; c < 4 * (n + 2) + 1; c++) begin
         if (out_valid[d]) begin
            chk($sformatf("b2b_out_d%0d_%0d", d, out_n), out_state[d], sub_state(s0, out_n[0]));
            out_n++;
         end
         if (in_ready[d]) begin
            in_mode[d] = acc_n[0];
            if (acc_n > 0) chk($sformatf("b2b_gap_d%0d_%0d", d, acc_n), 128'(c - prev), 128'(n + 2));
            prev = c;
            acc_n++;
         end
         @(negedge clk);
      end
      in_valid[d] = 1'b0;
      chk($sformatf("b2b_accepts_d%0d", d), 128'(acc_n), 128'(5));
      chk($sformatf("b2b_outputs_d%0d", d), 128'(out_n), 128'(4));
      w = 0;
      while (!in_ready[d] && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("b2b_drain_d%0d", d), 128'(in_ready[d]), 128'(1));
      out_ready[d] = 1'b0;
   endtask

   initial begin
      logic [127:0] r, r2, s, a_st, b_st;
      int           lat, w;

      fwd_tab = '{
         8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
         8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
         8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
         8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
         8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
         8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
         8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
         8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
         8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
         8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
         8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
         8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
         8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
         8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
         8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
         8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
      };
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_mode   = '0;
      out_ready = '0;
      for (int d = 0; d < 5; d++) in_state[d] = '0;

      repeat (3) @(negedge clk);
      for (int d = 0; d < 5; d++) begin
         chk($sformatf("rst_flags_d%0d", d), 128'({in_ready[d], out_valid[d], busy[d]}), 128'(3'b100));
         chk($sformatf("rst_out_d%0d", d), out_state[d], '0);
      end
      rst_n = 1'b1;

      xfer(2, 1'b0, '0, r, lat);
      chk("fwd_zero", r, {16{8'h63}});
      chk("fwd_zero_lat", 128'(lat), 128'(4));
      chk("idle_after", 128'({in_ready[2], out_valid[2], busy[2]}), 128'(3'b100));
      xfer(2, 1'b1, {16{8'h63}}, r, lat);
      chk("inv_63", r, '0);
      xfer(2, 1'b1, '0, r, lat);
      chk("inv_zero", r, {16{8'h52}});
      xfer(2, 1'b0, 128'h53, r, lat);
      chk("fwd_53", r, {{15{8'h63}}, 8'hed});
      xfer(2, 1'b1, 128'hed, r, lat);
      chk("inv_ed", r, {{15{8'h52}}, 8'h53});

      for (int d = 0; d < 5; d++) begin
         for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16 * j + i);
            xfer(d, 1'b0, s, r, lat);
            chk($sformatf("fwd_d%0d_s%0d", d, j), r, sub_state(s, 1'b0));
            chk($sformatf("lat_d%0d_s%0d", d, j), 128'(lat), 128'(16 >> d));
            xfer(d, 1'b1, r, r2, lat);
            chk($sformatf("round_d%0d_s%0d", d, j), r2, s);
            xfer(d, 1'b1, s, r, lat);
            chk($sformatf("inv_d%0d_s%0d", d, j), r, sub_state(s, 1'b1));
         end
      end

      // Backpressure with a second offer held during RUN/DONE and in_mode wiggling
      a_st = 128'h00112233_44556677_8899aabb_ccddeeff;
      b_st = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
      @(negedge clk);
      out_ready[2] = 1'b0;
      in_state[2]  = a_st;
      in_mode[2]   = 1'b0;
      in_valid[2]  = 1'b1;
      @(negedge clk);
      chk("bp_busy", 128'({busy[2], in_ready[2]}), 128'(2'b10));
      in_state[2] = b_st;
      w = 0;
      while (!out_valid[2] && w < 50) begin
         in_mode[2] = ~in_mode[2];
         @(negedge clk);
         w++;
      end
      chk("bp_lat", 128'(w), 128'(4));
      chk("bp_result", out_state[2], sub_state(a_st, 1'b0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_%0d", i), out_state[2], sub_state(a_st, 1'b0));
         chk($sformatf("bp_flags_%0d", i), 128'({out_valid[2], in_ready[2]}), 128'(2'b10));
      end
      out_ready[2] = 1'b1;
      in_mode[2]   = 1'b1;
      @(negedge clk);
      out_ready[2] = 1'b0;
      chk("bp_idle", 128'({in_ready[2], out_valid[2]}), 128'(2'b10));
      @(negedge clk);
      in_valid[2] = 1'b0;
      chk("bp_second_accept", 128'(busy[2]), 128'(1));
      w = 0;
      while (!out_valid[2] && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("bp_second", out_state[2], sub_state(b_st, 1'b1));
      out_ready[2] = 1'b1;
      @(negedge clk);
      out_ready[2] = 1'b0;

      // Reset during the second RUN cycle
      @(negedge clk);
      in_state[2] = a_st;
      in_mode[2]  = 1'b0;
      in_valid[2] = 1'b1;
      @(negedge clk);
      in_valid[2] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_run_flags", 128'({in_ready[2], out_valid[2], busy[2]}), 128'(3'b100));
      chk("rst_run_out", out_state[2], '0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(2, 1'b1, b_st, r, lat);
      chk("post_rst", r, sub_state(b_st, 1'b1));
      chk("post_rst_lat", 128'(lat), 128'(4));

      back_to_back(2, a_st);
      back_to_back(4, b_st);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
